lcd_frame_sequencer: RTL and testbench

- AHB-Lite master that programs and feeds the LCD drive slave for one frame per start pulse.
- Occupies the master-0 slot on the AHB-Lite interconnect, in place of the dummy RISC master.
- Sequence per frame: configuration writes, pixel-stream writes from a valid/ready source, status polling until the slave reports frame done, then done/error to the host.
- One transfer in flight at a time: address phase, then data phase; no pipelined back-to-back address phases.

---
 rtl/lcd_frame_sequencer_pkg.sv | 39 +++
 rtl/lcd_frame_sequencer_ahb_single_xfer.sv | 79 +++++++
 rtl/lcd_frame_sequencer.sv | 172 +++++++++++++++++
 tb/tb_lcd_frame_sequencer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_frame_sequencer_pkg.sv
// Shared constants and types for the LCD frame sequencer and its AHB transfer engine.
package lcd_seq_pkg;

  // AHB-Lite encodings, same values as amba_ahb_h.v
  localparam int unsigned W_BURST       = 3;
  localparam logic [1:0]  HTRANS_IDLE   = 2'b00;
  localparam logic [1:0]  HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0]  HBURST_SINGLE = 3'b000;
  localparam logic [2:0]  HSIZE_WORD    = 3'b010;
  localparam logic [1:0]  HRESP_OKAY    = 2'b00;
  localparam logic [1:0]  HRESP_ERROR   = 2'b01;

  // Default slave base; matches `RISCV_LCD_DRIVE_BASE_ADDR on the reference platform
  localparam logic [31:0] LCD_BASE_DEFAULT = 32'h4000_0000;

  // LCD drive slave register map
  localparam logic [7:0] CTRL     = 8'h00;
  localparam logic [7:0] IMG_SIZE = 8'h04;
  localparam logic [7:0] PIX_DATA = 8'h08;
  localparam logic [7:0] STATUS   = 8'h0C;

  localparam int unsigned CTRL_ENABLE = 0;
  localparam int unsigned STATUS_DONE = 0;

  typedef enum logic [2:0] {
    ST_IDLE, ST_CFG_SIZE, ST_CFG_CTRL, ST_STREAM, ST_POLL, ST_DONE, ST_ERR
  } seq_state_e;

  typedef enum logic [1:0] {
    XF_IDLE, XF_ADDR, XF_DATA
  } xfer_phase_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_HRESP   = 2'd1,
    ERR_TIMEOUT = 2'd2
  } seq_err_e;

endpackage

// File: rtl/lcd_frame_sequencer_ahb_single_xfer.sv
// Non-pipelined AHB-Lite single-transfer engine: one address phase, then one data phase.
module ahb_single_xfer
  import lcd_seq_pkg::*;
#(
  parameter int unsigned W_ADDR = 32,
  parameter int unsigned W_DATA = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_i,
  input  logic [W_ADDR-1:0] addr_i,
  input  logic              write_i,
  input  logic [W_DATA-1:0] wdata_i,
  output logic              idle_o,
  output logic              ack_o,
  output logic              err_o,
  output logic [W_DATA-1:0] rdata_o,
  output logic [W_ADDR-1:0] haddr_o,
  output logic [W_DATA-1:0] hwdata_o,
  output logic              hwrite_o,
  output logic [1:0]        htrans_o,
  input  logic [W_DATA-1:0] hrdata_i,
  input  logic [1:0]        hresp_i,
  input  logic              hready_i
);

  xfer_phase_e       phase_q, phase_d;
  logic [W_ADDR-1:0] addr_q, addr_d;
  logic              write_q, write_d;
  logic [W_DATA-1:0] wdata_q, wdata_d;
  logic              issue;

  // A request is taken straight onto the bus in the cycle it is presented, so
  // the requester can tie its own handshake to that exact address cycle.
  assign issue    = (phase_q == XF_IDLE) && req_i;
  assign idle_o   = (phase_q == XF_IDLE);
  assign ack_o    = (phase_q == XF_DATA) && hready_i;
  assign err_o    = ack_o && (hresp_i == HRESP_ERROR);
  assign rdata_o  = hrdata_i;
  assign htrans_o = (issue || phase_q == XF_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign haddr_o  = (phase_q == XF_IDLE) ? addr_i : addr_q;
  assign hwrite_o = (phase_q == XF_IDLE) ? write_i : write_q;
  assign hwdata_o = wdata_q;

  // Next phase and captured transfer attributes
  always_comb begin
    phase_d = phase_q;
    addr_d  = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;
    unique case (phase_q)
      XF_IDLE: if (req_i) begin
        addr_d  = addr_i;
        write_d = write_i;
        wdata_d = wdata_i;
        phase_d = hready_i ? XF_DATA : XF_ADDR;
      end
      XF_ADDR: if (hready_i) phase_d = XF_DATA;
      XF_DATA: if (hready_i) phase_d = XF_IDLE;
      default: phase_d = XF_IDLE;
    endcase
  end

  // Phase and transfer registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      phase_q <= XF_IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
    end else begin
      phase_q <= phase_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
    end
  end

endmodule

// File: rtl/lcd_frame_sequencer.sv
// AHB-Lite master that configures the LCD drive slave, streams one frame of pixels and polls for completion.
module lcd_frame_sequencer
  import lcd_seq_pkg::*;
#(
  parameter int unsigned       W_ADDR   = 32,
  parameter int unsigned       W_DATA   = 32,
  parameter int unsigned       W_CNT    = 16,
  parameter int unsigned       POLL_MAX = 1024,
  parameter logic [W_ADDR-1:0] LCD_BASE = W_ADDR'(LCD_BASE_DEFAULT)
) (
  input  logic               HCLK,
  input  logic               HRESETn,
  input  logic               i_start,
  input  logic [31:0]        i_img_size,
  input  logic [W_CNT-1:0]   i_num_words,
  input  logic               i_pix_valid,
  input  logic [31:0]        i_pix_data,
  output logic               o_pix_ready,
  output logic               o_busy,
  output logic               o_done,
  output logic [1:0]         o_err,
  output logic [W_ADDR-1:0]  o_HADDR,
  output logic [W_DATA-1:0]  o_HWDATA,
  output logic               o_HWRITE,
  output logic [2:0]         o_HSIZE,
  output logic [W_BURST-1:0] o_HBURST,
  output logic [1:0]         o_HTRANS,
  input  logic [W_DATA-1:0]  i_HRDATA,
  input  logic [1:0]         i_HRESP,
  input  logic               i_HREADY
);

  localparam int unsigned W_POLL = $clog2(POLL_MAX + 1);
  localparam logic [W_ADDR-1:0] A_CTRL     = LCD_BASE + W_ADDR'(CTRL);
  localparam logic [W_ADDR-1:0] A_IMG_SIZE = LCD_BASE + W_ADDR'(IMG_SIZE);
  localparam logic [W_ADDR-1:0] A_PIX_DATA = LCD_BASE + W_ADDR'(PIX_DATA);
  localparam logic [W_ADDR-1:0] A_STATUS   = LCD_BASE + W_ADDR'(STATUS);

  seq_state_e        state_q;
  logic [W_DATA-1:0] img_size_q;
  logic [W_CNT-1:0]  cnt_q;
  logic [W_POLL-1:0] poll_q;
  seq_err_e          err_q;
  logic              busy_q;
  logic              done_q;

  logic              xf_req, xf_write, xf_idle, xf_ack, xf_err;
  logic [W_ADDR-1:0] xf_addr;
  logic [W_DATA-1:0] xf_wdata, xf_rdata;
  logic              rdata_unused;

  assign rdata_unused = ^xf_rdata;

  assign o_busy   = busy_q;
  assign o_done   = done_q;
  assign o_err    = err_q;
  assign o_HSIZE  = HSIZE_WORD;
  assign o_HBURST = HBURST_SINGLE;

  // Transfer request for the current state; a pixel is accepted only in the cycle its address goes out
  always_comb begin
    xf_req      = 1'b0;
    xf_addr     = '0;
    xf_write    = 1'b0;
    xf_wdata    = '0;
    o_pix_ready = 1'b0;
    unique case (state_q)
      ST_CFG_SIZE: begin
        xf_req   = 1'b1;
        xf_addr  = A_IMG_SIZE;
        xf_write = 1'b1;
        xf_wdata = img_size_q;
      end
      ST_CFG_CTRL: begin
        xf_req   = 1'b1;
        xf_addr  = A_CTRL;
        xf_write = 1'b1;
        xf_wdata = W_DATA'(1) << CTRL_ENABLE;
      end
      ST_STREAM: begin
        xf_req      = i_pix_valid;
        xf_addr     = A_PIX_DATA;
        xf_write    = 1'b1;
        xf_wdata    = W_DATA'(i_pix_data);
        o_pix_ready = i_pix_valid && xf_idle;
      end
      ST_POLL: begin
        xf_req  = 1'b1;
        xf_addr = A_STATUS;
      end
      default: ;
    endcase
  end

  ahb_single_xfer #(
    .W_ADDR (W_ADDR),
    .W_DATA (W_DATA)
  ) u_xfer (
    .clk_i    (HCLK),
    .rst_ni   (HRESETn),
    .req_i    (xf_req),
    .addr_i   (xf_addr),
    .write_i  (xf_write),
    .wdata_i  (xf_wdata),
    .idle_o   (xf_idle),
    .ack_o    (xf_ack),
    .err_o    (xf_err),
    .rdata_o  (xf_rdata),
    .haddr_o  (o_HADDR),
    .hwdata_o (o_HWDATA),
    .hwrite_o (o_HWRITE),
    .htrans_o (o_HTRANS),
    .hrdata_i (i_HRDATA),
    .hresp_i  (i_HRESP),
    .hready_i (i_HREADY)
  );

  // Frame sequencing FSM with registered status outputs
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q    <= ST_IDLE;
      img_size_q <= '0;
      cnt_q      <= '0;
      poll_q     <= '0;
      err_q      <= ERR_NONE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (xf_ack && xf_err) begin
        state_q <= ST_ERR;
        err_q   <= ERR_HRESP;
      end else begin
        unique case (state_q)
          ST_IDLE: if (i_start) begin
            img_size_q <= W_DATA'(i_img_size);
            cnt_q      <= i_num_words;
            poll_q     <= '0;
            err_q      <= ERR_NONE;
            busy_q     <= 1'b1;
            state_q    <= ST_CFG_SIZE;
          end
          ST_CFG_SIZE: if (xf_ack) state_q <= ST_CFG_CTRL;
          ST_CFG_CTRL: if (xf_ack) state_q <= (cnt_q == '0) ? ST_POLL : ST_STREAM;
          ST_STREAM: if (xf_ack) begin
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == W_CNT'(1)) state_q <= ST_POLL;
          end
          ST_POLL: if (xf_ack) begin
            if (xf_rdata[STATUS_DONE]) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else if (poll_q == W_POLL'(POLL_MAX - 1)) begin
              state_q <= ST_ERR;
              err_q   <= ERR_TIMEOUT;
            end else begin
              poll_q <= poll_q + 1'b1;
            end
          end
          ST_DONE: state_q <= ST_IDLE;
          ST_ERR: begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lcd_frame_sequencer.sv
// Self-checking bench: AHB slave model with an expected-transfer scoreboard plus a valid/ready pixel source.
module tb_lcd_frame_sequencer;

  localparam logic [31:0] BASE     = 32'h5000_0000;
  localparam logic [1:0]  T_IDLE   = 2'b00;
  localparam logic [1:0]  T_NONSEQ = 2'b10;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b1;
  logic        i_start, i_pix_valid;
  logic [31:0] i_img_size, i_pix_data;
  logic [15:0] i_num_words;
  logic        o_pix_ready, o_busy, o_done, o_HWRITE;
  logic [1:0]  o_err, o_HTRANS;
  logic [31:0] o_HADDR, o_HWDATA;
  logic [2:0]  o_HSIZE, o_HBURST;
  logic [31:0] i_HRDATA;
  logic [1:0]  i_HRESP;
  logic        i_HREADY;

  int   errors = 0;
  int   checks = 0;
  txn_t exp_q[$];
  bit   sb_en = 1'b1;
  int   sl_waits = 0, sl_err_at = -1, sl_done_at = -1;
  int   xfer_idx, read_idx, nonseq_cnt, ready_cnt, done_cnt;
  logic [31:0] words [16];
  logic [1:0]  err_after_start;

  always #5 HCLK = ~HCLK;

  lcd_frame_sequencer #(
    .POLL_MAX (8),
    .LCD_BASE (BASE)
  ) dut (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .i_start     (i_start),
    .i_img_size  (i_img_size),
    .i_num_words (i_num_words),
    .i_pix_valid (i_pix_valid),
    .i_pix_data  (i_pix_data),
    .o_pix_ready (o_pix_ready),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_err       (o_err),
    .o_HADDR     (o_HADDR),
    .o_HWDATA    (o_HWDATA),
    .o_HWRITE    (o_HWRITE),
    .o_HSIZE     (o_HSIZE),
    .o_HBURST    (o_HBURST),
    .o_HTRANS    (o_HTRANS),
    .i_HRDATA    (i_HRDATA),
    .i_HRESP     (i_HRESP),
    .i_HREADY    (i_HREADY)
  );

  // AHB slave model: drives HREADY/HRESP/HRDATA at the falling edge and pops the scoreboard per data phase
  initial begin : slave
    bit          dphase, dp_err, dp_wr;
    int          dp_wait;
    logic [31:0] dp_addr, dp_wdata;
    txn_t        e;
    dphase = 0; dp_err = 0; dp_wr = 0; dp_wait = 0; dp_addr = '0; dp_wdata = '0;
    i_HREADY = 1'b1; i_HRESP = 2'b00; i_HRDATA = '0;
    forever begin
      @(negedge HCLK);
      if (!HRESETn) begin
        dphase = 0; i_HREADY = 1'b1; i_HRESP = 2'b00;
      end else begin
        if (o_pix_ready) ready_cnt++;
        if (o_done) done_cnt++;
        if (dphase) begin
          if (dp_wait == 0) dp_wdata = o_HWDATA;
          if (sb_en && (dp_wait > 0 || o_HTRANS !== T_IDLE)) begin
            checks++;
            if (o_HWDATA !== dp_wdata || o_HADDR !== dp_addr || o_HTRANS !== T_IDLE) begin
              errors++;
              $display("FAIL data_phase_hold: HADDR=%h HWDATA=%h HTRANS=%b required HADDR=%h HWDATA=%h HTRANS=00",
                       o_HADDR, o_HWDATA, o_HTRANS, dp_addr, dp_wdata);
            end
          end
          if (dp_err ? (dp_wait == 0) : (dp_wait < sl_waits)) begin
            i_HREADY = 1'b0; i_HRESP = dp_err ? 2'b01 : 2'b00; dp_wait++;
          end else begin
            i_HREADY = 1'b1; i_HRESP = dp_err ? 2'b01 : 2'b00;
            i_HRDATA = dp_wr ? 32'h0 : ((read_idx == sl_done_at) ? 32'h0000_0001 : 32'hFFFF_FFFE);
            if (!dp_wr) read_idx++;
            dphase = 0;
            if (sb_en) begin
              checks++;
              if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_xfer: wr=%0b addr=%h data=%h required no transfer", dp_wr, dp_addr, dp_wdata);
              end else begin
                e = exp_q.pop_front();
                if (e.wr !== dp_wr || e.addr !== dp_addr || (dp_wr && e.data !== dp_wdata)) begin
                  errors++;
                  $display("FAIL xfer_order: wr=%0b addr=%h data=%h required wr=%0b addr=%h data=%h",
                           dp_wr, dp_addr, dp_wdata, e.wr, e.addr, e.data);
                end
              end
            end
          end
        end else begin
          i_HREADY = 1'b1; i_HRESP = 2'b00;
          if (o_HTRANS === T_NONSEQ) begin
            dphase = 1; dp_wait = 0; dp_addr = o_HADDR; dp_wr = o_HWRITE;
            dp_err = (xfer_idx == sl_err_at);
            xfer_idx++; nonseq_cnt++;
          end
        end
      end
    end
  end

  // Push the expected bus sequence, pulse start, and feed pixels until the frame ends
  task automatic run_frame(input logic [31:0] img, input int n, input int period,
                           input int n_exp_pix, input int n_reads);
    int idx, cyc, guard;
    exp_q.push_back('{1'b1, BASE + 32'h04, img});
    exp_q.push_back('{1'b1, BASE + 32'h00, 32'h1});
    for (int i = 0; i < n; i++) begin
      words[i] = $urandom;
      if (i < n_exp_pix) exp_q.push_back('{1'b1, BASE + 32'h08, words[i]});
    end
    for (int i = 0; i < n_reads; i++) exp_q.push_back('{1'b0, BASE + 32'h0C, 32'h0});
    ready_cnt = 0; done_cnt = 0; nonseq_cnt = 0; xfer_idx = 0; read_idx = 0;
    @(posedge HCLK); #1;
    i_img_size = img; i_num_words = 16'(n); i_start = 1'b1;
    @(posedge HCLK); #1;
    i_start = 1'b0;
    err_after_start = o_err;
    idx = 0; cyc = 0;
    for (guard = 0; guard < 4000; guard++) begin
      i_pix_valid = (idx < n) && (cyc % period == 0);
      i_pix_data  = (idx < n) ? words[idx] : 32'h0;
      @(negedge HCLK);
      if (i_pix_valid && o_pix_ready) idx++;
      if (!o_busy) break;
      @(posedge HCLK); #1;
      cyc++;
    end
    i_pix_valid = 1'b0;
    if (guard == 4000) begin
      errors++;
      $display("FAIL frame_timeout: o_busy=%0b after 4000 cycles required 0", o_busy);
    end
    repeat (2) @(posedge HCLK);
    #1;
  endtask

  task automatic test_reset();
    #1 HRESETn = 1'b0;
    #2;
    checks++;
    if (o_HTRANS !== T_IDLE || o_HSIZE !== 3'b010 || o_HBURST !== 3'b000 || o_HADDR !== 32'h0 ||
        o_HWDATA !== 32'h0 || o_HWRITE !== 1'b0) begin
      errors++;
      $display("FAIL reset_bus: HTRANS=%b HSIZE=%b HBURST=%b HADDR=%h HWDATA=%h HWRITE=%b required 00 010 000 0 0 0",
               o_HTRANS, o_HSIZE, o_HBURST, o_HADDR, o_HWDATA, o_HWRITE);
    end
    checks++;
    if (o_busy !== 1'b0 || o_done !== 1'b0 || o_err !== 2'd0 || o_pix_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_status: busy=%b done=%b err=%0d pix_ready=%b required 0 0 0 0",
               o_busy, o_done, o_err, o_pix_ready);
    end
    repeat (2) @(posedge HCLK);
    #3 HRESETn = 1'b1;
    repeat (2) @(posedge HCLK);
  endtask

  task automatic test_basic_frame();
    sl_waits = 0; sl_err_at = -1; sl_done_at = 2;
    run_frame(32'h0020_0010, 4, 1, 4, 3);
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL basic_done: pulses=%0d required 1", done_cnt); end
    checks++; if (o_err !== 2'd0) begin errors++; $display("FAIL basic_err: o_err=%0d required 0", o_err); end
    checks++; if (ready_cnt !== 4) begin errors++; $display("FAIL basic_ready: pulses=%0d required 4", ready_cnt); end
    checks++; if (nonseq_cnt !== 9) begin errors++; $display("FAIL basic_nonseq: count=%0d required 9", nonseq_cnt); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL basic_left: pending=%0d required 0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    sl_waits = 2; sl_err_at = -1; sl_done_at = 0;
    run_frame(32'h0010_0008, 4, 3, 4, 1);
    checks++; if (ready_cnt !== 4) begin errors++; $display("FAIL bp_ready: pulses=%0d required 4", ready_cnt); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL bp_done: pulses=%0d required 1", done_cnt); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL bp_left: pending=%0d required 0", exp_q.size()); end
  endtask

  task automatic test_zero_words();
    sl_waits = 0; sl_err_at = -1; sl_done_at = 1;
    run_frame(32'h0000_0001, 0, 1, 0, 2);
    checks++; if (ready_cnt !== 0) begin errors++; $display("FAIL zero_ready: pulses=%0d required 0", ready_cnt); end
    checks++; if (nonseq_cnt !== 4) begin errors++; $display("FAIL zero_nonseq: count=%0d required 4", nonseq_cnt); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL zero_done: pulses=%0d required 1", done_cnt); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL zero_left: pending=%0d required 0", exp_q.size()); end
  endtask

  task automatic test_hresp_error();
    sl_waits = 1; sl_err_at = 3; sl_done_at = -1;
    run_frame(32'h0040_0020, 4, 1, 2, 0);
    checks++; if (o_err !== 2'd1) begin errors++; $display("FAIL hresp_code: o_err=%0d required 1", o_err); end
    checks++; if (done_cnt !== 0) begin errors++; $display("FAIL hresp_done: pulses=%0d required 0", done_cnt); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL hresp_busy: o_busy=%b required 0", o_busy); end
    checks++; if (nonseq_cnt !== 4) begin errors++; $display("FAIL hresp_nonseq: count=%0d required 4", nonseq_cnt); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL hresp_left: pending=%0d required 0", exp_q.size()); end
    sl_waits = 0; sl_err_at = -1; sl_done_at = 0;
    run_frame(32'h0000_0002, 2, 1, 2, 1);
    checks++; if (err_after_start !== 2'd0) begin errors++; $display("FAIL hresp_clear: o_err=%0d required 0", err_after_start); end
    checks++; if (done_cnt !== 1 || o_err !== 2'd0) begin errors++; $display("FAIL hresp_recover: done=%0d err=%0d required 1 0", done_cnt, o_err); end
  endtask

  task automatic test_poll_timeout();
    sl_waits = 0; sl_err_at = -1; sl_done_at = -1;
    run_frame(32'h0001_0001, 1, 1, 1, 8);
    checks++; if (read_idx !== 8) begin errors++; $display("FAIL poll_reads: count=%0d required 8", read_idx); end
    checks++; if (o_err !== 2'd2) begin errors++; $display("FAIL poll_code: o_err=%0d required 2", o_err); end
    checks++; if (done_cnt !== 0) begin errors++; $display("FAIL poll_done: pulses=%0d required 0", done_cnt); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL poll_left: pending=%0d required 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid_stream();
    bit seen;
    sl_waits = 2; sl_err_at = -1; sl_done_at = -1; sb_en = 1'b0;
    @(posedge HCLK); #1;
    i_img_size = 32'h0008_0004; i_num_words = 16'd4; i_start = 1'b1;
    @(posedge HCLK); #1;
    i_start = 1'b0; i_pix_valid = 1'b1; i_pix_data = 32'hA5A5_0001;
    seen = 0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge HCLK);
      if (o_pix_ready) seen = 1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL rst_stream_reach: pix_ready=0 required 1"); end
    @(posedge HCLK); #2 HRESETn = 1'b0;
    #1;
    checks++;
    if (o_HTRANS !== T_IDLE || o_HADDR !== 32'h0 || o_HWDATA !== 32'h0 || o_HWRITE !== 1'b0) begin
      errors++;
      $display("FAIL rst_stream_bus: HTRANS=%b HADDR=%h HWDATA=%h HWRITE=%b required 00 0 0 0",
               o_HTRANS, o_HADDR, o_HWDATA, o_HWRITE);
    end
    checks++;
    if (o_busy !== 1'b0 || o_pix_ready !== 1'b0 || o_done !== 1'b0 || o_err !== 2'd0) begin
      errors++;
      $display("FAIL rst_stream_status: busy=%b pix_ready=%b done=%b err=%0d required 0 0 0 0",
               o_busy, o_pix_ready, o_done, o_err);
    end
    i_pix_valid = 1'b0;
    @(posedge HCLK); #3 HRESETn = 1'b1;
    exp_q.delete();
    sb_en = 1'b1;
    repeat (2) @(posedge HCLK);
    sl_waits = 0; sl_done_at = 0;
    run_frame(32'h0003_0002, 2, 1, 2, 1);
    checks++; if (done_cnt !== 1 || o_err !== 2'd0) begin errors++; $display("FAIL rst_recover: done=%0d err=%0d required 1 0", done_cnt, o_err); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL rst_left: pending=%0d required 0", exp_q.size()); end
  endtask

  initial begin
    i_start = 1'b0; i_img_size = '0; i_num_words = '0; i_pix_valid = 1'b0; i_pix_data = '0;
    err_after_start = '0;
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_zero_words();
    test_hresp_error();
    test_poll_timeout();
    test_reset_mid_stream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
